// File: rtl/poly_fir_4lane.sv
// poly_fir_4lane: four-lane parallel (polyphase) 4-tap FIR filter.
// Each cycle carries four consecutive samples x[4t+0..3]. Taps reaching back
// before the group use lanes 1..3 of the previous accepted group.
// Pipeline: input/history capture -> products -> sum, shift, saturate.
module poly_fir_4lane #(
    parameter int NB_DATA  = 8,
    parameter int NB_COEFF = 8,
    parameter int NB_OUT   = 8,
    parameter int SHIFT    = 7,
    parameter int COEFF_0  = 32,
    parameter int COEFF_1  = 32,
    parameter int COEFF_2  = 32,
    parameter int COEFF_3  = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_signal_0,
    input  logic [NB_DATA-1:0]  i_signal_1,
    input  logic [NB_DATA-1:0]  i_signal_2,
    input  logic [NB_DATA-1:0]  i_signal_3,
    input  logic                i_valid,
    output logic [NB_OUT-1:0]   o_signal_0,
    output logic [NB_OUT-1:0]   o_signal_1,
    output logic [NB_OUT-1:0]   o_signal_2,
    output logic [NB_OUT-1:0]   o_signal_3,
    output logic                o_valid,
    output logic                o_sat
);

    localparam int NB_PROD = NB_DATA + NB_COEFF;
    // Four full-precision products need two guard bits so the sum never wraps.
    localparam int NB_SUM  = NB_PROD + 2;

    localparam logic signed [NB_SUM-1:0] OUT_MAX = NB_SUM'((1 <<< (NB_OUT - 1)) - 1);
    localparam logic signed [NB_SUM-1:0] OUT_MIN = -OUT_MAX - NB_SUM'(1);

    logic signed [NB_COEFF-1:0] coeff [4];
    logic signed [NB_DATA-1:0]  in_c  [4];

    assign coeff[0] = NB_COEFF'(COEFF_0);
    assign coeff[1] = NB_COEFF'(COEFF_1);
    assign coeff[2] = NB_COEFF'(COEFF_2);
    assign coeff[3] = NB_COEFF'(COEFF_3);

    assign in_c[0] = $signed(i_signal_0);
    assign in_c[1] = $signed(i_signal_1);
    assign in_c[2] = $signed(i_signal_2);
    assign in_c[3] = $signed(i_signal_3);

    // Sample window: [0..2] = lanes 1..3 of the previous accepted group,
    // [3..6] = lanes 0..3 of the current group. Lane k, tap m reads win_r[k+3-m].
    logic signed [NB_DATA-1:0] win_r [7];
    logic                      valid_s1;

    // Stage 1: capture the new group and slide the history, only on accepted groups.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the whole window is reset because a reset must leave zero history behind.
            for (int i = 0; i < 7; i++) win_r[i] <= '0;
            valid_s1 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let win_r[i+4] be read as its old value here.
            valid_s1 <= i_valid;
            if (i_valid) begin
                for (int i = 0; i < 3; i++) win_r[i] <= win_r[i + 4];
                for (int k = 0; k < 4; k++) win_r[k + 3] <= in_c[k];
            end
        end
    end

    logic signed [NB_PROD-1:0] prod_r [4][4];
    logic                      valid_s2;

    // Stage 2: sixteen full-precision products (lane x tap).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++)
                for (int m = 0; m < 4; m++)
                    prod_r[k][m] <= '0;
            valid_s2 <= 1'b0;
        end else begin
            valid_s2 <= valid_s1;
            if (valid_s1) begin
                for (int k = 0; k < 4; k++)
                    for (int m = 0; m < 4; m++)
                        prod_r[k][m] <= NB_PROD'(win_r[k + 3 - m]) * NB_PROD'(coeff[m]);
            end
        end
    end

    logic signed [NB_SUM-1:0] sum_c  [4];
    logic signed [NB_SUM-1:0] shf_c  [4];
    logic        [NB_OUT-1:0] sat_c  [4];
    logic        [3:0]        clip_c;

    // Sum, arithmetic shift (floor) and clamp for each lane.
    always_comb begin
        // NOTE: every output of this block is assigned before any branch so no latch is inferred.
        clip_c = '0;
        for (int k = 0; k < 4; k++) begin
            sum_c[k] = NB_SUM'(prod_r[k][0]) + NB_SUM'(prod_r[k][1])
                     + NB_SUM'(prod_r[k][2]) + NB_SUM'(prod_r[k][3]);
            shf_c[k] = sum_c[k] >>> SHIFT;
            sat_c[k] = shf_c[k][NB_OUT-1:0];
            if (shf_c[k] > OUT_MAX) begin
                sat_c[k]  = OUT_MAX[NB_OUT-1:0];
                clip_c[k] = 1'b1;
            end else if (shf_c[k] < OUT_MIN) begin
                sat_c[k]  = OUT_MIN[NB_OUT-1:0];
                clip_c[k] = 1'b1;
            end
        end
    end

    logic [NB_OUT-1:0] out_r [4];

    // Stage 3: output registers; they hold their last values through bubbles.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++) out_r[k] <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= valid_s2;
            if (valid_s2) begin
                for (int k = 0; k < 4; k++) out_r[k] <= sat_c[k];
                o_sat <= |clip_c;
            end
        end
    end

    assign o_signal_0 = out_r[0];
    assign o_signal_1 = out_r[1];
    assign o_signal_2 = out_r[2];
    assign o_signal_3 = out_r[3];

endmodule

// File: tb/tb_poly_fir_4lane.sv
// Testbench for poly_fir_4lane: a default-coefficient instance and an
// all-127 instance share the same stimulus; expected groups go to a queue
// when driven and are popped when o_valid is seen.
module tb_poly_fir_4lane;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_signal_0, i_signal_1, i_signal_2, i_signal_3;
    logic       i_valid;

    logic [7:0] d_o0, d_o1, d_o2, d_o3;
    logic       d_valid, d_sat;
    logic [7:0] b_o0, b_o1, b_o2, b_o3;
    logic       b_valid, b_sat;

    always #5 i_clock = ~i_clock;

    poly_fir_4lane dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_signal_0 (i_signal_0),
        .i_signal_1 (i_signal_1),
        .i_signal_2 (i_signal_2),
        .i_signal_3 (i_signal_3),
        .i_valid    (i_valid),
        .o_signal_0 (d_o0),
        .o_signal_1 (d_o1),
        .o_signal_2 (d_o2),
        .o_signal_3 (d_o3),
        .o_valid    (d_valid),
        .o_sat      (d_sat)
    );

    poly_fir_4lane #(
        .COEFF_0 (127),
        .COEFF_1 (127),
        .COEFF_2 (127),
        .COEFF_3 (127)
    ) dut_big (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_signal_0 (i_signal_0),
        .i_signal_1 (i_signal_1),
        .i_signal_2 (i_signal_2),
        .i_signal_3 (i_signal_3),
        .i_valid    (i_valid),
        .o_signal_0 (b_o0),
        .o_signal_1 (b_o1),
        .o_signal_2 (b_o2),
        .o_signal_3 (b_o3),
        .o_valid    (b_valid),
        .o_sat      (b_sat)
    );

    typedef struct packed {
        logic [3:0][7:0] y_d;
        logic            sat_d;
        logic [3:0][7:0] y_b;
        logic            sat_b;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       held;
    logic [2:0] vline;
    int         hist[3];
    int         h_def[4] = '{32, 32, 32, 32};
    int         h_big[4] = '{127, 127, 127, 127};
    int         n_checks;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: y[n] = sat((sum h[m]*x[n-m]) >>> 7), history from previous group.
    function automatic void filt(input int x[4], input int h[4],
                                 output logic [3:0][7:0] y, output logic sat);
        int w[7];
        int acc;
        sat = 1'b0;
        for (int j = 0; j < 3; j++) w[j] = hist[j];
        for (int j = 0; j < 4; j++) w[j + 3] = x[j];
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int m = 0; m < 4; m++) acc += h[m] * w[k + 3 - m];
            acc = acc >>> 7;
            if (acc > 127) begin
                acc = 127;
                sat = 1'b1;
            end else if (acc < -128) begin
                acc = -128;
                sat = 1'b1;
            end
            y[k] = 8'(acc);
        end
    endfunction

    task automatic check_outputs();
        exp_t e;
        check("o_valid_def", 32'(d_valid), 32'(vline[2]));
        check("o_valid_big", 32'(b_valid), 32'(vline[2]));
        if (d_valid) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL stray_output: observed o_valid=1 expected no pending group");
            end
            if (exp_q.size() != 0) begin
                e    = exp_q.pop_front();
                held = e;
                check("lanes_def", {d_o3, d_o2, d_o1, d_o0}, e.y_d);
                check("sat_def",   32'(d_sat), 32'(e.sat_d));
                check("lanes_big", {b_o3, b_o2, b_o1, b_o0}, e.y_b);
                check("sat_big",   32'(b_sat), 32'(e.sat_b));
            end
        end else begin
            check("hold_def", {d_o3, d_o2, d_o1, d_o0}, held.y_d);
            check("hold_big", {b_o3, b_o2, b_o1, b_o0}, held.y_b);
        end
    endtask

    // One cycle: check what the DUT shows now, then drive the next group.
    task automatic cyc(input bit v, input int a, input int b, input int c, input int d);
        int   x[4];
        exp_t e;
        @(negedge i_clock);
        check_outputs();
        x          = '{a, b, c, d};
        i_valid    = v;
        i_signal_0 = 8'(a);
        i_signal_1 = 8'(b);
        i_signal_2 = 8'(c);
        i_signal_3 = 8'(d);
        if (v) begin
            filt(x, h_def, e.y_d, e.sat_d);
            filt(x, h_big, e.y_b, e.sat_b);
            exp_q.push_back(e);
            hist = '{b, c, d};
        end
        vline = {vline[1:0], v};
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_def"}, {d_o3, d_o2, d_o1, d_o0}, 32'h0);
        check({tag, "_out_big"}, {b_o3, b_o2, b_o1, b_o0}, 32'h0);
        check({tag, "_flags"},   32'({d_valid, d_sat, b_valid, b_sat}), 32'h0);
    endtask

    // Reset asserted between clock edges while groups are in flight.
    task automatic mid_reset();
        @(posedge i_clock);
        #2;
        i_reset = 1'b1;
        i_valid = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge i_clock);
        #1;
        check_zero("rst_held");
        exp_q.delete();
        vline = '0;
        held  = '0;
        hist  = '{0, 0, 0};
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        i_valid    = 1'b0;
        i_signal_0 = '0;
        i_signal_1 = '0;
        i_signal_2 = '0;
        i_signal_3 = '0;
        vline      = '0;
        held       = '0;
        hist       = '{0, 0, 0};

        // Power-up reset.
        #1 i_reset = 1'b1;
        #2;
        check_zero("reset");
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;

        // Impulse in lane 0: all lanes 16, then zeros.
        cyc(1, 64, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);

        // Impulse in lane 3 crossing into the next group.
        cyc(1, 0, 0, 0, 64);
        repeat (3) cyc(1, 0, 0, 0, 0);

        // Full-scale steps (saturate only on the all-127 instance).
        repeat (5) cyc(1, 127, 127, 127, 127);
        repeat (5) cyc(1, -128, -128, -128, -128);

        // Bubbles with junk on the data lanes: valid pattern 1,0,0,1.
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 64, 0, 0, 0);
        cyc(0, 99, -77, 55, 13);
        cyc(0, -1, 120, -100, 7);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 42, 42, 42, 42);

        // Random back-to-back stream with occasional bubbles.
        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128);
        end

        // Load nonzero history, reset mid-stream, then repeat the impulse.
        cyc(1, 50, -70, 100, -30);
        cyc(1, -90, 20, 110, -5);
        mid_reset();
        cyc(1, 64, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
